mac_tcdm_responder: RTL and testbench
=====================================

# mac_tcdm_responder

Banked TCDM responder that sits on the slave end of the accelerator's `tcdm[MP-1:0]` master ports. It models the cluster shared memory as `N_BANKS` word-interleaved 32-bit banks with per-bank round-robin arbitration and a fixed one-cycle response latency. It is used as the memory side of block-level and top-level testbenches, and in FPGA/standalone builds of the accelerator. It also exposes a conflict counter for measuring streamer efficiency.

## Interface
- `MP`, 4, number of TCDM slave ports; must match the accelerator master count.
- `N_BANKS`, 4, number of banks; power of two, ≥1.
- `BANK_WORDS`, 256, 32-bit words per bank; power of two.
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `tcdm`  slave  `hwpe_stream_intf_tcdm` [MP-1:0]  request fields `req`, `add`[31:0], `wen`, `be`[3:0], `data`[31:0]; response fields `gnt`, `r_data`[31:0], `r_valid`.
- `clear_i`  in  1  synchronous soft clear of arbiter pointers and counter; memory is untouched.
- `conflict_cnt_o`  out  32  saturating count of cycles in which at least one `req` was not granted.

## Operation
- Address decode: word index `w = add[W+1:2]`, where `W = log2(N_BANKS*BANK_WORDS)`. Bank = `w % N_BANKS`, row = `w / N_BANKS`. Bits `add[31:W+2]` and `add[1:0]` are ignored, so addresses wrap modulo the memory size.
- `wen=1` is a read; `wen=0` is a write. A write updates only the bytes whose `be` bit is 1. A read ignores `be`.
- Each bank services at most one request per cycle.
- Arbitration is per bank and round-robin over ports. Each bank keeps a pointer `rr[b]`. Among ports requesting bank `b`, the grant goes to the first port at or after `rr[b]` (cyclic search).
  - After a grant to port `p`, `rr[b] <= (p+1) % MP`.
  - A bank with no grant keeps its pointer.
- `gnt[p]` is combinational from the current-cycle `req`/`add`. `gnt` is never asserted without `req`.
- Ports targeting different banks are all granted in the same cycle.
- Response: one cycle after `gnt[p]`, `r_valid[p]=1`.
  - Read: `r_data[p]` holds the array word as it was before any write in that grant cycle. No two grants ever hit the same bank in one cycle.
  - Write: `r_data[p]=0`.
  - `r_valid` is a single-cycle pulse per grant and has no back-pressure. The master must accept it.
- An ungranted request is not stored. The master holds `req`/`add`/`wen`/`be`/`data` stable until granted, and the responder re-arbitrates every cycle.
- A write in cycle N followed by a read of the same word in cycle N+1 or later returns the written data.
- Counter: `conflict_cnt_o` increments by 1 in each cycle where any `req[p] & ~gnt[p]` holds, and saturates at `32'hFFFF_FFFF`.
- Reset (`rst_ni=0` at a clock edge): `r_valid`=0, `r_data`=0, all `rr`=0, `conflict_cnt_o`=0.
  - Memory contents are not reset.
  - Responses for requests granted in the cycle of reset are dropped.
  - While `rst_ni=0`, all `gnt` are 0.
- `clear_i=1`: `rr`=0 and counter=0 at the next edge. Grants and responses continue normally. If reset and clear are both asserted, reset wins (the result is identical).

## Timing
- Request to grant: 0 cycles, combinational.
- Grant to `r_valid`/`r_data`: exactly 1 cycle, registered.
- Throughput: 1 access per bank per cycle, so peak is `min(MP, N_BANKS)` accesses per cycle.
- Worst-case wait for a continuously requesting port: `MP-1` cycles, from the round-robin bound.
- Outputs after reset: `gnt`=0 (driven by `req`), `r_valid`=0, `r_data`=0, `conflict_cnt_o`=0.

## Configuration
- `MAC_TCDM_RESPONDER_STALL_EN` defined:
  - A 16-bit Fibonacci LFSR with taps 16, 14, 13, 11 is seeded to `16'hACE1` on reset and `clear_i`, and advances every cycle.
  - When `lfsr[0]=1`, all grants in that cycle are suppressed. Those cycles count as conflicts if any `req` is high, and no `rr` pointer moves.
- Macro undefined:
  - No LFSR is present and grants are never suppressed.

## Test plan
- Write then read: port 0 writes `0xDEADBEEF` to `0x100` with `be=4'hF`, then reads `0x100`. Expect `gnt` in the request cycle, `r_valid` one cycle later, and read `r_data=0xDEADBEEF`.
- Byte enable: word at `0x40` holds `0x11223344`. Write `0xAABBCCDD` with `be=4'b0101`, then read. Expect `0x11BB33DD`.
- Bank conflict: ports 0–3 all continuously read bank 0 (addresses `0x0`, `0x10`, `0x20`, `0x30`), all preloaded. Expect grants in order 0, 1, 2, 3, 0, one per cycle, and `conflict_cnt_o` incrementing every cycle.
- Parallel banks: ports 0–3 read `0x0`, `0x4`, `0x8`, `0xC` in the same cycle. Expect all 4 `gnt` and all 4 `r_valid` the next cycle, with no counter increment.
- Wrap-around (default parameters, 4 KiB): write `0x55` to `0x1004`, read `0x004`. Expect `0x55`.
- Reset mid-operation: assert `rst_ni=0` in the cycle of a granted read. Expect `r_valid=0` the next cycle, `conflict_cnt_o=0`, and the arbiter restarting from port 0. Memory retains the earlier written data.

Source files
------------

// File: rtl/mac_tcdm_responder.sv
// ============================================================================
// Module   : mac_tcdm_responder
// Purpose  : Banked TCDM slave model. N_BANKS word-interleaved 32-bit banks,
//            per-bank round-robin arbitration over MP ports, combinational
//            grant and a registered one-cycle response. Counts cycles in which
//            any request was left ungranted.
// Ports    : clk_i, rst_ni (sync, active-low), clear_i (soft clear of
//            arbiter pointers and counter)
//            tcdm_*_i / tcdm_*_o : the MP TCDM ports, flattened; port p
//            occupies slice [p*32 +: 32] of add/data/r_data, [p*4 +: 4] of be
//            and bit p of req/wen/gnt/r_valid. wen=1 is a read.
//            conflict_cnt_o : saturating count of conflict cycles
// Options  : MAC_TCDM_RESPONDER_STALL_EN - adds a 16-bit LFSR that randomly
//            suppresses all grants in a cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_tcdm_responder #(
  parameter int MP         = 4,
  parameter int N_BANKS    = 4,
  parameter int BANK_WORDS = 256
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic [MP-1:0]     tcdm_req_i,
  input  logic [MP*32-1:0]  tcdm_add_i,
  input  logic [MP-1:0]     tcdm_wen_i,
  input  logic [MP*4-1:0]   tcdm_be_i,
  input  logic [MP*32-1:0]  tcdm_data_i,
  output logic [MP-1:0]     tcdm_gnt_o,
  output logic [MP*32-1:0]  tcdm_r_data_o,
  output logic [MP-1:0]     tcdm_r_valid_o,
  output logic [31:0]       conflict_cnt_o
);

  localparam int WORD_BITS = $clog2(N_BANKS * BANK_WORDS);
  localparam int LOG_BANKS = $clog2(N_BANKS);
  localparam int BANK_BITS = (N_BANKS > 1) ? LOG_BANKS : 1;
  localparam int ROW_BITS  = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;
  localparam int PTR_BITS  = (MP > 1) ? $clog2(MP) : 1;
  localparam logic [WORD_BITS-1:0] BANK_MASK = WORD_BITS'(N_BANKS - 1);

  // Storage (not reset: contents survive rst_ni and clear_i)
  logic [31:0]          mem_q [N_BANKS][BANK_WORDS];

  // Per-port decode
  logic [BANK_BITS-1:0] port_bank  [MP];
  logic [ROW_BITS-1:0]  port_row   [MP];
  logic [31:0]          port_rdata [MP];

  // Per-bank winner selection
  logic [PTR_BITS-1:0]  rr_d [N_BANKS];
  logic [PTR_BITS-1:0]  rr_q [N_BANKS];
  logic                 bank_hit   [N_BANKS];
  logic                 bank_we    [N_BANKS];
  logic [ROW_BITS-1:0]  bank_row   [N_BANKS];
  logic [3:0]           bank_be    [N_BANKS];
  logic [31:0]          bank_wdata [N_BANKS];
  int                   arb_idx;

  logic [MP-1:0]        req_eff;
  logic [MP-1:0]        gnt;
  logic                 stall;
  logic                 conflict;

  logic [MP-1:0]        r_valid_d, r_valid_q;
  logic [MP*32-1:0]     r_data_d, r_data_q;
  logic [31:0]          cnt_d, cnt_q;

  // --------------------------------------------------------------------------
  // Address decode: word index splits into bank (low bits) and row (high bits);
  // address bits above the memory size and the byte offset are ignored.
  // --------------------------------------------------------------------------
  generate
    for (genvar p = 0; p < MP; p++) begin : g_port
      logic [WORD_BITS-1:0] word;
      assign word          = tcdm_add_i[p*32+2 +: WORD_BITS];
      assign port_bank[p]  = BANK_BITS'(word & BANK_MASK);
      assign port_row[p]   = ROW_BITS'(word >> LOG_BANKS);
      // Old array contents: a write granted this cycle lands only at the edge
      assign port_rdata[p] = mem_q[port_bank[p]][port_row[p]];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Optional random stall source
  // --------------------------------------------------------------------------
`ifdef MAC_TCDM_RESPONDER_STALL_EN
  logic [15:0] lfsr_d, lfsr_q;
  logic        lfsr_fb;

  // Fibonacci form, taps 16/14/13/11 expressed on a right-shifting register
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  always_comb begin
    lfsr_d = {lfsr_fb, lfsr_q[15:1]};
    if (clear_i) begin
      lfsr_d = 16'hACE1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Arbitration: per bank, first requesting port at or after rr[b] (cyclic)
  // --------------------------------------------------------------------------
  always_comb begin
    req_eff = tcdm_req_i & {MP{rst_ni & ~stall}};
    gnt     = '0;
    arb_idx = 0;
    for (int b = 0; b < N_BANKS; b++) begin
      rr_d[b]       = rr_q[b];
      bank_hit[b]   = 1'b0;
      bank_we[b]    = 1'b0;
      bank_row[b]   = '0;
      bank_be[b]    = '0;
      bank_wdata[b] = '0;
      for (int k = 0; k < MP; k++) begin
        arb_idx = (int'(rr_q[b]) + k) % MP;
        if (!bank_hit[b] && req_eff[arb_idx] &&
            (port_bank[arb_idx] == BANK_BITS'(b))) begin
          bank_hit[b]   = 1'b1;
          gnt[arb_idx]  = 1'b1;
          rr_d[b]       = PTR_BITS'((arb_idx + 1) % MP);
          bank_we[b]    = ~tcdm_wen_i[arb_idx];
          bank_row[b]   = port_row[arb_idx];
          bank_be[b]    = tcdm_be_i[arb_idx*4 +: 4];
          bank_wdata[b] = tcdm_data_i[arb_idx*32 +: 32];
        end
      end
      if (clear_i) begin
        rr_d[b] = '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response and conflict counter next-state
  // --------------------------------------------------------------------------
  always_comb begin
    r_valid_d = gnt;
    r_data_d  = '0;
    for (int p = 0; p < MP; p++) begin
      if (gnt[p] && tcdm_wen_i[p]) begin
        r_data_d[p*32 +: 32] = port_rdata[p];
      end
    end
  end

  assign conflict = |(tcdm_req_i & ~gnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (conflict && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_valid_q <= '0;
      r_data_q  <= '0;
      cnt_q     <= '0;
      for (int b = 0; b < N_BANKS; b++) begin
        rr_q[b] <= '0;
      end
    end else begin
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      cnt_q     <= cnt_d;
      for (int b = 0; b < N_BANKS; b++) begin
        rr_q[b] <= rr_d[b];
      end
    end
  end

  // Byte-enabled bank writes; grants are already gated by reset
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < N_BANKS; b++) begin
      for (int i = 0; i < 4; i++) begin
        if (bank_we[b] && bank_be[b][i]) begin
          mem_q[b][bank_row[b]][i*8 +: 8] <= bank_wdata[b][i*8 +: 8];
        end
      end
    end
  end

  assign tcdm_gnt_o     = gnt;
  assign tcdm_r_valid_o = r_valid_q;
  assign tcdm_r_data_o  = r_data_q;
  assign conflict_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_tcdm_responder.sv
// ============================================================================
// Module   : tb_mac_tcdm_responder
// Purpose  : Directed self-checking bench for mac_tcdm_responder (default
//            parameters: 4 ports, 4 banks, 256 words per bank).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_tcdm_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic [3:0]   req, wen, gnt, r_valid;
  logic [127:0] add, data, r_data;
  logic [15:0]  be;
  logic [31:0]  cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] pre_a [7] = '{32'h0, 32'h10, 32'h20, 32'h30, 32'h4, 32'h8, 32'hC};
  logic [31:0] pre_d [7] = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222,
                             32'hA333_3333, 32'hB111_1111, 32'hB222_2222,
                             32'hB333_3333};

  always #5 clk = ~clk;

  mac_tcdm_responder #(
    .MP         (4),
    .N_BANKS    (4),
    .BANK_WORDS (256)
  ) u_dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .clear_i        (clear),
    .tcdm_req_i     (req),
    .tcdm_add_i     (add),
    .tcdm_wen_i     (wen),
    .tcdm_be_i      (be),
    .tcdm_data_i    (data),
    .tcdm_gnt_o     (gnt),
    .tcdm_r_data_o  (r_data),
    .tcdm_r_valid_o (r_valid),
    .conflict_cnt_o (cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic w,
                          input logic [3:0] b, input logic [31:0] d);
    add[p*32 +: 32]  = a;
    wen[p]           = w;
    be[p*4 +: 4]     = b;
    data[p*32 +: 32] = d;
    req[p]           = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd(input int p);
    return r_data[p*32 +: 32];
  endfunction

  // One access on one port: grant in the request cycle, response one later
  task automatic single_access(input string tag, input int p,
                               input logic [31:0] a, input logic w,
                               input logic [3:0] b, input logic [31:0] d,
                               input logic [31:0] exp_rdata);
    set_port(p, a, w, b, d);
    #1;
    check_val({tag, "_gnt"}, {28'b0, gnt}, 32'(1 << p));
    next_cycle();
    req = '0;
    check_val({tag, "_rvalid"}, {28'b0, r_valid}, 32'(1 << p));
    check_val({tag, "_rdata"}, rd(p), exp_rdata);
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    req   = '0;
    add   = '0;
    wen   = '1;
    be    = '0;
    data  = '0;

    // Reset: grants held low even with a request present
    set_port(0, 32'h100, 1'b1, 4'hF, 32'h0);
    next_cycle();
    check_val("rst_gnt", {28'b0, gnt}, 32'h0);
    next_cycle();
    check_val("rst_rvalid", {28'b0, r_valid}, 32'h0);
    check_val("rst_rdata0", rd(0), 32'h0);
    check_val("rst_cnt", cnt, 32'h0);
    req   = '0;
    rst_n = 1'b1;
    next_cycle();

    // Write then read
    single_access("wr100", 0, 32'h100, 1'b0, 4'hF, 32'hDEAD_BEEF, 32'h0);
    single_access("rd100", 0, 32'h100, 1'b1, 4'hF, 32'h0, 32'hDEAD_BEEF);

    // Byte enables; the read uses be=0 since reads ignore it
    single_access("be_init", 0, 32'h40, 1'b0, 4'hF, 32'h1122_3344, 32'h0);
    single_access("be_wr", 0, 32'h40, 1'b0, 4'b0101, 32'hAABB_CCDD, 32'h0);
    single_access("be_rd", 0, 32'h40, 1'b1, 4'h0, 32'h0, 32'h11BB_33DD);

    // Preload for conflict / parallel tests
    for (int i = 0; i < 7; i++) begin
      single_access("pre", 0, pre_a[i], 1'b0, 4'hF, pre_d[i], 32'h0);
    end

    // Restart arbiter pointers before the conflict run
    clear = 1'b1;
    next_cycle();
    clear = 1'b0;

    // Bank conflict: all four ports hammer bank 0
    for (int p = 0; p < 4; p++) begin
      set_port(p, 32'(p * 16), 1'b1, 4'hF, 32'h0);
    end
    for (int k = 0; k < 5; k++) begin
      #1;
      check_val("conf_gnt", {28'b0, gnt}, 32'(1 << (k % 4)));
      next_cycle();
      check_val("conf_rvalid", {28'b0, r_valid}, 32'(1 << (k % 4)));
      check_val("conf_rdata", rd(k % 4), pre_d[k % 4]);
      check_val("conf_cnt", cnt, 32'(k + 1));
    end
    req = '0;

    // Clear resets the counter and the bank-0 pointer (which sits at port 1)
    clear = 1'b1;
    next_cycle();
    clear = 1'b0;
    check_val("clr_cnt", cnt, 32'h0);
    set_port(0, 32'h0, 1'b1, 4'hF, 32'h0);
    set_port(1, 32'h10, 1'b1, 4'hF, 32'h0);
    #1;
    check_val("clr_rr_gnt", {28'b0, gnt}, 32'h1);
    next_cycle();
    req = '0;
    check_val("clr_rr_rvalid", {28'b0, r_valid}, 32'h1);
    check_val("clr_rr_cnt", cnt, 32'h1);

    // Parallel banks: no conflict, all granted together
    for (int p = 0; p < 4; p++) begin
      set_port(p, 32'(p * 4), 1'b1, 4'hF, 32'h0);
    end
    #1;
    check_val("par_gnt", {28'b0, gnt}, 32'hF);
    next_cycle();
    req = '0;
    check_val("par_rvalid", {28'b0, r_valid}, 32'hF);
    for (int p = 0; p < 4; p++) begin
      check_val("par_rdata", rd(p), pre_d[(p == 0) ? 0 : p + 3]);
    end
    check_val("par_cnt", cnt, 32'h1);

    // Address wrap-around modulo 4 KiB
    single_access("wrap_wr", 0, 32'h1004, 1'b0, 4'hF, 32'h55, 32'h0);
    single_access("wrap_rd", 0, 32'h004, 1'b1, 4'hF, 32'h0, 32'h55);

    // Reset mid-operation (bank-0 pointer currently at port 1)
    set_port(0, 32'h100, 1'b1, 4'hF, 32'h0);
    rst_n = 1'b0;
    #1;
    check_val("rstm_gnt", {28'b0, gnt}, 32'h0);
    next_cycle();
    req   = '0;
    rst_n = 1'b1;
    check_val("rstm_rvalid", {28'b0, r_valid}, 32'h0);
    check_val("rstm_cnt", cnt, 32'h0);

    set_port(0, 32'h0, 1'b1, 4'hF, 32'h0);
    set_port(1, 32'h10, 1'b1, 4'hF, 32'h0);
    #1;
    check_val("rstm_rr_gnt", {28'b0, gnt}, 32'h1);
    next_cycle();
    req[0] = 1'b0;
    check_val("rstm_rdata0", rd(0), pre_d[0]);
    #1;
    check_val("rstm_gnt1", {28'b0, gnt}, 32'h2);
    next_cycle();
    req = '0;
    check_val("rstm_rdata1", rd(1), pre_d[1]);
    single_access("rstm_keep", 0, 32'h100, 1'b1, 4'hF, 32'h0, 32'hDEAD_BEEF);

    next_cycle();
    check_val("idle_rvalid", {28'b0, r_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
